// File: rtl/aud_i2s_rx_pkg.sv
// Shared audio definitions for the I2S capture and playback paths.
// Holds the slot/frame geometry, the receiver FSM state encoding and the
// wclk polarity. The playback serializer uses the same polarity, so both
// directions agree on which slot is right.
package aud_i2s_rx_pkg;

    localparam int   SLOT_BITS   = 16;
    localparam int   FRAME_BCLKS = 32;
    localparam logic WCLK_RIGHT  = 1'b1;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_RIGHT = 2'd1,
        ST_LEFT  = 2'd2
    } aud_rx_state_e;

endpackage

// File: rtl/aud_edge_det.sv
// Rising-edge detector for a slow clock-like signal sampled in a faster
// clock domain (BCLK sampled by gClk). The signal is treated as data.
//   clk_i   : sampling clock
//   rst_n_i : asynchronous active-low reset
//   sig_i   : signal to watch
//   rise_o  : high for one clk_i cycle when the registered signal goes 0->1
module aud_edge_det (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sig_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sig_q  <= sig_i;
            prev_q <= sig_q;
        end
    end

    assign rise_o = sig_q & ~prev_q;

endmodule

// File: rtl/aud_i2s_rx.sv
// I2S capture receiver for the codec ADC path. Deserializes sdin against the
// bclk/wclk pair (32 BCLK per frame, 16-bit MSB-first slots, right slot first,
// no one-bit delay) and presents each completed frame as a right/left pair
// with a one-gClk valid strobe. Framing errors drop back to SYNC and are
// counted in a saturating counter.
//   gClk, reset_n      : clock and asynchronous active-low reset
//   bclk, wclk, sdin   : serial interface, all sampled as data in gClk
//   enable             : low holds the receiver in SYNC
//   err_clr            : pulse clearing frame_err and err_count
//   left, right, valid : last complete frame and its update strobe
//   locked             : a good frame has been seen since the last sync
//   frame_err          : sticky framing-error flag
//   err_count          : saturating framing-error count
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_SYNC  | waiting for a wclk 0->1 transition to start a right slot
// ST_RIGHT | shifting in the right slot (wclk high)
// ST_LEFT  | shifting in the left slot (wclk low)
module aud_i2s_rx #(
    parameter int SLOT_BITS = aud_i2s_rx_pkg::SLOT_BITS,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 gClk,
    input  logic                 reset_n,
    input  logic                 bclk,
    input  logic                 wclk,
    input  logic                 sdin,
    input  logic                 enable,
    input  logic                 err_clr,
    output logic [SLOT_BITS-1:0] left,
    output logic [SLOT_BITS-1:0] right,
    output logic                 valid,
    output logic                 locked,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    import aud_i2s_rx_pkg::*;

    localparam int                CNT_W    = $clog2(SLOT_BITS + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    aud_rx_state_e          state_q, state_d;
    logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
    logic [SLOT_BITS-1:0]   shift_q, shift_d;
    logic [SLOT_BITS-1:0]   hold_q, hold_d;
    logic [SLOT_BITS-1:0]   left_q, left_d;
    logic [SLOT_BITS-1:0]   right_q, right_d;
    logic                   valid_q, valid_d;
    logic                   locked_q, locked_d;
    logic                   wclk_last_q, wclk_last_d;
    logic                   frame_err_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;

    logic                   bclk_rise;
    logic                   wclk_chg;
    logic                   slot_full;
    logic                   err_evt;
    logic [SLOT_BITS-1:0]   shift_in;

    aud_edge_det u_bclk_det (
        .clk_i   (gClk),
        .rst_n_i (reset_n),
        .sig_i   (bclk),
        .rise_o  (bclk_rise)
    );

    assign wclk_chg  = (wclk != wclk_last_q);
    assign slot_full = (bitcnt_q == CNT_FULL);
    assign shift_in  = {shift_q[SLOT_BITS-2:0], sdin};

    // State register plus the datapath registers that move with it.
    always_ff @(posedge gClk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_SYNC;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            // Starting at 1 means the first rise can never look like 0->1.
            wclk_last_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            wclk_last_q <= wclk_last_d;
        end
    end

    // Next state. A slot boundary is only legal with a full slot, and a full
    // slot must be followed by a boundary; anything else is a framing error.
    always_comb begin
        state_d = state_q;
        err_evt = 1'b0;
        if (!enable) begin
            state_d = ST_SYNC;
        end else if (bclk_rise) begin
            unique case (state_q)
                ST_SYNC: begin
                    if (wclk == WCLK_RIGHT && wclk_last_q != WCLK_RIGHT) begin
                        state_d = ST_RIGHT;
                    end
                end
                ST_RIGHT: begin
                    if (wclk_chg && slot_full) begin
                        state_d = ST_LEFT;
                    end else if (wclk_chg || slot_full) begin
                        state_d = ST_SYNC;
                        err_evt = 1'b1;
                    end
                end
                ST_LEFT: begin
                    if (wclk_chg && slot_full) begin
                        state_d = ST_RIGHT;
                    end else if (wclk_chg || slot_full) begin
                        state_d = ST_SYNC;
                        err_evt = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                end
            endcase
        end
    end

    // Datapath and outputs.
    always_comb begin
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        wclk_last_d = bclk_rise ? wclk : wclk_last_q;
        if (!enable) begin
            bitcnt_d = '0;
            locked_d = 1'b0;
        end else if (bclk_rise) begin
            if (err_evt) begin
                bitcnt_d = '0;
                locked_d = 1'b0;
            end else if (state_q == ST_SYNC) begin
                if (state_d == ST_RIGHT) begin
                    shift_d  = shift_in;
                    bitcnt_d = CNT_ONE;
                end
            end else begin
                shift_d = shift_in;
                if (state_d == state_q) begin
                    bitcnt_d = bitcnt_q + CNT_ONE;
                end else begin
                    // The boundary bit is already the first bit of the new slot.
                    bitcnt_d = CNT_ONE;
                    if (state_q == ST_RIGHT) begin
                        hold_d = shift_q;
                    end else begin
                        left_d   = shift_q;
                        right_d  = hold_q;
                        valid_d  = 1'b1;
                        locked_d = 1'b1;
                    end
                end
            end
        end
    end

    // Error flag and saturating counter. A new error beats a coincident clear.
    always_ff @(posedge gClk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else if (err_evt) begin
            frame_err_q <= 1'b1;
            if (err_clr) begin
                err_cnt_q <= ERR_CNT_W'(1);
            end else if (~&err_cnt_q) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
        end else if (err_clr) begin
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end
    end

    assign left      = left_q;
    assign right     = right_q;
    assign valid     = valid_q;
    assign locked    = locked_q;
    assign frame_err = frame_err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_aud_i2s_rx.sv
// Scoreboard bench for aud_i2s_rx. The driver pushes the expected right/left
// pair for every well-formed frame; a monitor pops and compares on each valid.
module tb_aud_i2s_rx;

    import aud_i2s_rx_pkg::*;

    localparam int SB         = 16;
    localparam int EW         = 8;
    localparam int FRAME_GCLK = 2 * FRAME_BCLKS;

    logic          gClk    = 1'b0;
    logic          reset_n = 1'b0;
    logic          bclk    = 1'b0;
    logic          wclk    = 1'b0;
    logic          sdin    = 1'b0;
    logic          enable  = 1'b0;
    logic          err_clr = 1'b0;
    logic [SB-1:0] left;
    logic [SB-1:0] right;
    logic          valid;
    logic          locked;
    logic          frame_err;
    logic [EW-1:0] err_count;

    aud_i2s_rx #(.SLOT_BITS(SB), .ERR_CNT_W(EW)) dut (
        .gClk      (gClk),
        .reset_n   (reset_n),
        .bclk      (bclk),
        .wclk      (wclk),
        .sdin      (sdin),
        .enable    (enable),
        .err_clr   (err_clr),
        .left      (left),
        .right     (right),
        .valid     (valid),
        .locked    (locked),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    always #5 gClk = ~gClk;

    typedef struct packed {
        logic [SB-1:0] r;
        logic [SB-1:0] l;
    } pair_t;

    pair_t exp_q[$];
    int    n_cmp       = 0;
    int    n_err       = 0;
    int    n_valid     = 0;
    int    exp_valid   = 0;
    int    cyc         = 0;
    int    last_cyc    = 0;
    bit    have_prev   = 1'b0;
    bit    chk_spacing = 1'b0;
    logic  valid_prev  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling gClk edge, away from the DUT's edge.
    always @(negedge gClk) begin
        pair_t e;
        cyc++;
        if (!chk_spacing) have_prev = 1'b0;
        if (valid === 1'b1) begin
            n_valid++;
            if (valid_prev === 1'b1) check("valid_width", 32'(valid_prev), 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid: got valid=1 right=0x%0h left=0x%0h, expected no frame pending",
                         right, left);
            end else begin
                e = exp_q.pop_front();
                check("right", 32'(right), 32'(e.r));
                check("left", 32'(left), 32'(e.l));
                check("locked_at_valid", 32'(locked), 32'd1);
            end
            if (chk_spacing && have_prev) check("valid_gap", 32'(cyc - last_cyc), 32'(FRAME_GCLK));
            last_cyc  = cyc;
            have_prev = 1'b1;
        end
        valid_prev = valid;
    end

    // One BCLK period: bclk low for a gClk, then high with the new bit.
    task automatic send_bit(input logic w, input logic d);
        @(negedge gClk);
        bclk = 1'b0;
        @(negedge gClk);
        bclk = 1'b1;
        wclk = w;
        sdin = d;
    endtask

    task automatic send_frame(input logic [SB-1:0] r, input logic [SB-1:0] l,
                              input int rbits, input int lbits);
        for (int i = 0; i < rbits; i++) send_bit(1'b1, r[SB-1-i]);
        for (int i = 0; i < lbits; i++) send_bit(1'b0, l[SB-1-i]);
    endtask

    task automatic good_frame(input logic [SB-1:0] r, input logic [SB-1:0] l);
        exp_q.push_back({r, l});
        exp_valid++;
        send_frame(r, l, SB, SB);
    endtask

    task automatic settle();
        repeat (6) @(negedge gClk);
    endtask

    // Return to SYNC with wclk low without creating a framing error.
    task automatic resync();
        @(negedge gClk);
        enable = 1'b0;
        repeat (3) send_bit(1'b0, 1'b0);
        @(negedge gClk);
        enable = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_left"}, 32'(left), 32'd0);
        check({tag, "_right"}, 32'(right), 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no end of stimulus, expected finish within 50000 cycles");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge gClk);
        reset_n = 1'b1;
        @(negedge gClk);
        check_reset_outputs("reset");
        enable = 1'b1;

        // First frame, then 8 back-to-back incrementing frames.
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        chk_spacing = 1'b1;
        good_frame(16'h1234, 16'hABCD);
        for (int i = 0; i < 8; i++) good_frame(16'h3000 + 16'(i), 16'hC000 + 16'(i));
        send_bit(1'b1, 1'b0);
        settle();
        chk_spacing = 1'b0;
        check("burst_valid_count", 32'(n_valid), 32'(exp_valid));
        check("burst_frame_err", 32'(frame_err), 32'd0);
        check("burst_locked", 32'(locked), 32'd1);
        resync();

        // Right slot one bit short.
        send_frame(16'h5555, 16'hAAAA, SB - 1, SB);
        check("short_frame_err", 32'(frame_err), 32'd1);
        check("short_err_count", 32'(err_count), 32'd1);
        check("short_locked", 32'(locked), 32'd0);
        check("short_no_valid", 32'(n_valid), 32'(exp_valid));
        good_frame(16'h0F0F, 16'hF0F0);
        send_bit(1'b1, 1'b0);
        settle();
        check("recover_valid_count", 32'(n_valid), 32'(exp_valid));
        check("recover_locked", 32'(locked), 32'd1);
        resync();

        // 300 minimal malformed frames: saturate the counter.
        for (int i = 0; i < 300; i++) begin
            send_bit(1'b1, 1'b1);
            send_bit(1'b0, 1'b0);
        end
        settle();
        check("sat_err_count", 32'(err_count), 32'hFF);
        check("sat_frame_err", 32'(frame_err), 32'd1);
        check("sat_no_valid", 32'(n_valid), 32'(exp_valid));
        @(negedge gClk);
        err_clr = 1'b1;
        @(negedge gClk);
        err_clr = 1'b0;
        @(negedge gClk);
        check("clr_err_count", 32'(err_count), 32'd0);
        check("clr_frame_err", 32'(frame_err), 32'd0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        @(negedge gClk);
        err_clr = 1'b1;
        @(negedge gClk);
        err_clr = 1'b0;
        @(negedge gClk);
        check("clr_vs_err_count", 32'(err_count), 32'd1);
        check("clr_vs_err_flag", 32'(frame_err), 32'd1);

        // Reset in the middle of the left slot.
        send_frame(16'h5A5A, 16'hC3C3, SB, 8);
        @(negedge gClk);
        reset_n = 1'b0;
        @(negedge gClk);
        check_reset_outputs("midreset");
        @(negedge gClk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1);
        check("midreset_no_valid", 32'(n_valid), 32'(exp_valid));
        good_frame(16'h1357, 16'h2468);
        send_bit(1'b1, 1'b0);
        settle();
        check("midreset_valid_count", 32'(n_valid), 32'(exp_valid));

        // Enable dropped for three frames.
        @(negedge gClk);
        enable = 1'b0;
        send_frame(16'hDEAD, 16'hBEEF, SB, SB);
        send_frame(16'hCAFE, 16'hF00D, SB, SB);
        send_frame(16'h0123, 16'h4567, SB, SB);
        @(negedge gClk);
        check("dis_no_valid", 32'(n_valid), 32'(exp_valid));
        check("dis_right_hold", 32'(right), 32'h1357);
        check("dis_left_hold", 32'(left), 32'h2468);
        check("dis_locked", 32'(locked), 32'd0);
        check("dis_err_count", 32'(err_count), 32'd0);
        enable = 1'b1;
        good_frame(16'h4321, 16'h8765);
        send_bit(1'b1, 1'b0);
        settle();
        check("reen_valid_count", 32'(n_valid), 32'(exp_valid));
        check("reen_frame_err", 32'(frame_err), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
